// File: rtl/instr_exec_unit.sv
// Execution stage behind the instruction register: single-cycle ALU ops plus a
// 32-step restoring divider, with valid/ready handshakes on both sides.
module instr_exec_unit #(
    parameter int OP_WIDTH  = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_opcode,
    input  logic [OP_WIDTH-1:0]     in_op_a,
    input  logic [OP_WIDTH-1:0]     in_op_b,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*OP_WIDTH-1:0]   out_result,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    out_div_by_zero,
    output logic                    out_illegal_op
);

    localparam int RES_WIDTH = 2 * OP_WIDTH;
    localparam int CNT_WIDTH = $clog2(OP_WIDTH);

    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(OP_WIDTH - 1);
    localparam logic [OP_WIDTH-1:0]  OP_ONE   = OP_WIDTH'(1);
    localparam logic [RES_WIDTH-1:0] RES_ONE  = RES_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CNT_WIDTH-1:0]    cnt_r;
    logic [OP_WIDTH-1:0]     rem_r;
    logic [OP_WIDTH-1:0]     quo_r;
    logic [OP_WIDTH-1:0]     dvs_r;
    logic                    is_mod_r;
    logic                    neg_q_r;
    logic                    neg_r_r;
    logic                    out_valid_r;
    logic [RES_WIDTH-1:0]    out_result_r;
    logic [TAG_WIDTH-1:0]    out_tag_r;
    logic                    dbz_r;
    logic                    ill_r;

    logic                    in_ready_s;
    logic                    take_s;
    logic [RES_WIDTH-1:0]    a_ext_s;
    logic [RES_WIDTH-1:0]    b_ext_s;
    logic [RES_WIDTH-1:0]    alu_res_s;
    logic                    is_div_s;
    logic                    dbz_s;
    logic                    ill_s;
    logic [OP_WIDTH:0]       rem_shift_s;
    logic [OP_WIDTH:0]       diff_s;
    logic                    fits_s;
    logic [OP_WIDTH-1:0]     rem_next_s;
    logic [OP_WIDTH-1:0]     quo_next_s;
    logic [RES_WIDTH-1:0]    quo_wide_s;
    logic [RES_WIDTH-1:0]    rem_wide_s;
    logic [RES_WIDTH-1:0]    div_res_s;

    function automatic logic [OP_WIDTH-1:0] magnitude(input logic [OP_WIDTH-1:0] v);
        magnitude = v[OP_WIDTH-1] ? (~v + OP_ONE) : v;
    endfunction

    assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign take_s     = in_valid && in_ready_s;
    assign a_ext_s    = {{OP_WIDTH{in_op_a[OP_WIDTH-1]}}, in_op_a};
    assign b_ext_s    = {{OP_WIDTH{in_op_b[OP_WIDTH-1]}}, in_op_b};

    // Single-cycle result and flag decode for the instruction on the input port
    always_comb begin
        alu_res_s = {RES_WIDTH{1'b0}};
        is_div_s  = 1'b0;
        dbz_s     = 1'b0;
        ill_s     = 1'b0;
        case (in_opcode)
            OPC_ZERO:  alu_res_s = {RES_WIDTH{1'b0}};
            OPC_PASSA: alu_res_s = a_ext_s;
            OPC_PASSB: alu_res_s = b_ext_s;
            OPC_ADD:   alu_res_s = a_ext_s + b_ext_s;
            OPC_SUB:   alu_res_s = a_ext_s - b_ext_s;
            OPC_MULT:  alu_res_s = a_ext_s * b_ext_s;
            OPC_DIV, OPC_MOD: begin
                is_div_s = 1'b1;
                if (in_op_b == {OP_WIDTH{1'b0}}) begin
                    dbz_s = 1'b1;
                end else begin
                    dbz_s = 1'b0;
                end
            end
            default:   ill_s = 1'b1;
        endcase
    end

    // One restoring step on magnitudes; the final step's outputs feed the signed result
    always_comb begin
        rem_shift_s = {1'b0, rem_r[OP_WIDTH-2:0], quo_r[OP_WIDTH-1]};
        rem_shift_s[OP_WIDTH] = rem_r[OP_WIDTH-1];
        diff_s      = rem_shift_s - {1'b0, dvs_r};
        fits_s      = ~diff_s[OP_WIDTH];
        if (fits_s) begin
            rem_next_s = diff_s[OP_WIDTH-1:0];
        end else begin
            rem_next_s = rem_shift_s[OP_WIDTH-1:0];
        end
        quo_next_s = {quo_r[OP_WIDTH-2:0], fits_s};
        quo_wide_s = {{OP_WIDTH{1'b0}}, quo_next_s};
        rem_wide_s = {{OP_WIDTH{1'b0}}, rem_next_s};
        if (is_mod_r) begin
            div_res_s = neg_r_r ? (~rem_wide_s + RES_ONE) : rem_wide_s;
        end else begin
            div_res_s = neg_q_r ? (~quo_wide_s + RES_ONE) : quo_wide_s;
        end
    end

    // Control FSM with registered result, tag and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_WIDTH{1'b0}};
            rem_r        <= {OP_WIDTH{1'b0}};
            quo_r        <= {OP_WIDTH{1'b0}};
            dvs_r        <= {OP_WIDTH{1'b0}};
            is_mod_r     <= 1'b0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            out_valid_r  <= 1'b0;
            out_result_r <= {RES_WIDTH{1'b0}};
            out_tag_r    <= {TAG_WIDTH{1'b0}};
            dbz_r        <= 1'b0;
            ill_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (take_s) begin
                        out_tag_r <= in_tag;
                        dbz_r     <= dbz_s;
                        ill_r     <= ill_s;
                        if (is_div_s && !dbz_s) begin
                            state_r      <= DIV_BUSY;
                            cnt_r        <= CNT_LAST;
                            out_valid_r  <= 1'b0;
                            out_result_r <= {RES_WIDTH{1'b0}};
                            rem_r        <= {OP_WIDTH{1'b0}};
                            quo_r        <= magnitude(in_op_a);
                            dvs_r        <= magnitude(in_op_b);
                            is_mod_r     <= (in_opcode == OPC_MOD);
                            neg_q_r      <= in_op_a[OP_WIDTH-1] ^ in_op_b[OP_WIDTH-1];
                            neg_r_r      <= in_op_a[OP_WIDTH-1];
                        end else begin
                            state_r      <= DONE;
                            out_valid_r  <= 1'b1;
                            out_result_r <= alu_res_s;
                        end
                    end else if ((state_r == DONE) && out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DIV_BUSY: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                        state_r      <= DONE;
                        out_valid_r  <= 1'b1;
                        out_result_r <= div_res_s;
                    end else begin
                        state_r <= DIV_BUSY;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_r;
    assign out_result      = out_result_r;
    assign out_tag         = out_tag_r;
    assign out_div_by_zero = dbz_r;
    assign out_illegal_op  = ill_r;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Scoreboard bench for instr_exec_unit: directed instructions push expected
// results; an independent monitor pops and compares on each output transfer.
module tb_instr_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_tag;
    logic        out_div_by_zero;
    logic        out_illegal_op;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        logic        dbz;
        logic        ill;
        int          delay;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   first_seen = 1'b0;

    instr_exec_unit #(.OP_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_div_by_zero(out_div_by_zero), .out_illegal_op(out_illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples late in the low phase, pops on every output transfer
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got tag %0d result %0h with empty scoreboard", out_tag, out_result);
                end else begin
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        check("valid_delay", 80'(cyc - sb[0].acc), 80'(sb[0].delay));
                    end
                    if (out_ready) begin
                        check("result", 80'(out_result), 80'(sb[0].res));
                        check("tag", 80'(out_tag), 80'(sb[0].tag));
                        check("flags", 80'({out_div_by_zero, out_illegal_op}), 80'({sb[0].dbz, sb[0].ill}));
                        void'(sb.pop_front());
                        first_seen = 1'b0;
                    end
                end
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 after the accepting edge
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [63:0] res, input logic dbz, input logic ill);
        int  waited = 0;
        bit  finished = 1'b0;
        int  d;
        d = ((op == 4'd6 || op == 4'd7) && b != 32'd0) ? 32 : 0;
        in_opcode = op;
        in_op_a   = a;
        in_op_b   = b;
        in_tag    = tag;
        in_valid  = 1'b1;
        while (!finished) begin
            #2;
            if (in_ready) begin
                sb.push_back(exp_t'{res, tag, dbz, ill, d, cyc + 1});
                finished = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: tag %0d not accepted after %0d cycles", tag, waited);
                    finished = 1'b1;
                end else begin
                    @(negedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int c0;
        int waited;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_opcode = 4'd0;
        in_op_a   = 32'd0;
        in_op_b   = 32'd0;
        in_tag    = 5'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("reset_out_valid", 80'(out_valid), 80'd0);
        check("reset_out_result", 80'(out_result), 80'd0);
        check("reset_out_tag", 80'(out_tag), 80'd0);
        check("reset_flags", 80'({out_div_by_zero, out_illegal_op}), 80'd0);
        check("reset_in_ready", 80'(in_ready), 80'd1);
        @(negedge clk);
        #1;

        send(4'd3, 32'd7, 32'hFFFF_FFFD, 5'd4, 64'd4, 1'b0, 1'b0);
        send(4'd5, 32'h8000_0000, 32'h8000_0000, 5'd1, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
        send(4'd2, 32'd9, 32'hFFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send(4'd1, 32'hFFFF_FFFB, 32'd3, 5'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0);
        send(4'd0, 32'd5, 32'd6, 5'd5, 64'd0, 1'b0, 1'b0);
        idle(2);

        // DIV -7/2: in_ready must stay low for all 32 busy cycles
        send(4'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
        lows = 0;
        for (int i = 0; i < 32; i++) begin
            #2;
            if (!in_ready) lows++;
            @(negedge clk);
            #1;
        end
        check("div_in_ready_low_cycles", 80'(lows), 80'd32);

        send(4'd7, 32'hFFFF_FFF9, 32'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
        send(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 64'd0, 1'b0, 1'b0);
        send(4'd6, 32'd100, 32'd7, 5'd10, 64'd14, 1'b0, 1'b0);
        send(4'd7, 32'd100, 32'hFFFF_FFF9, 5'd11, 64'd2, 1'b0, 1'b0);
        send(4'd6, 32'd7, 32'hFFFF_FFFE, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
        send(4'd6, 32'd5, 32'd0, 5'd13, 64'd0, 1'b1, 1'b0);
        send(4'hA, 32'd5, 32'd3, 5'd14, 64'd0, 1'b0, 1'b1);
        send(4'hF, 32'd1, 32'd1, 5'd15, 64'd0, 1'b0, 1'b1);
        idle(3);

        // Ten back-to-back ADDs with the consumer always ready
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            send(4'd3, 32'(i), 32'd10, 5'(16 + i), 64'(i + 10), 1'b0, 1'b0);
        end
        check("stream_cycles", 80'(cyc - c0), 80'd10);
        idle(2);

        // Stall the consumer: output fields must hold and no new instruction accepted
        out_ready = 1'b0;
        send(4'd4, 32'd50, 32'd8, 5'd26, 64'd42, 1'b0, 1'b0);
        in_opcode = 4'd3;
        in_op_a   = 32'd1;
        in_op_b   = 32'd1;
        in_tag    = 5'd27;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("stall_hold", {out_valid, in_ready, out_tag, out_result, out_div_by_zero, out_illegal_op},
                  {1'b1, 1'b0, 5'd26, 64'd42, 1'b0, 1'b0});
            @(negedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(2);

        // Reset in the middle of a division aborts it
        send(4'd6, 32'd1000, 32'd3, 5'd28, 64'd333, 1'b0, 1'b0);
        idle(9);
        reset = 1'b1;
        sb.delete();
        first_seen = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("abort_out_valid", 80'(out_valid), 80'd0);
        check("abort_in_ready", 80'(in_ready), 80'd1);
        @(negedge clk);
        #1;
        send(4'd4, 32'd1, 32'd2, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

        waited = 0;
        while (sb.size() > 0 && waited < 100) begin
            idle(1);
            waited++;
        end
        check("scoreboard_drained", 80'(sb.size()), 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
